// File: rtl/instr_exec_unit.sv
// rtl/instr_exec_unit.sv - walks a range of stored instructions and streams one result per location
// DIV/MOD run a magnitude restoring divider for OP_W cycles; other opcodes execute in one cycle.
module instr_exec_unit #(
  parameter int OP_W   = 32,
  parameter int RES_W  = 64,
  parameter int ADDR_W = 5
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_first_addr,
  input  logic [ADDR_W:0]   i_count,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_read_pointer,
  input  logic [3:0]        i_instr_opc,
  input  logic [OP_W-1:0]   i_instr_op_a,
  input  logic [OP_W-1:0]   i_instr_op_b,
  output logic              o_res_valid,
  input  logic              i_res_ready,
  output logic [ADDR_W-1:0] o_res_addr,
  output logic [3:0]        o_res_opc,
  output logic [RES_W-1:0]  o_res_data,
  output logic              o_res_div0
);

  localparam int CNT_W = $clog2(OP_W);
  localparam logic [CNT_W-1:0]  DIV_LAST = CNT_W'(OP_W - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [ADDR_W:0]   LEFT_ONE = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  localparam logic [3:0] OPC_ZERO  = 4'd0;
  localparam logic [3:0] OPC_PASSA = 4'd1;
  localparam logic [3:0] OPC_PASSB = 4'd2;
  localparam logic [3:0] OPC_ADD   = 4'd3;
  localparam logic [3:0] OPC_SUB   = 4'd4;
  localparam logic [3:0] OPC_MULT  = 4'd5;
  localparam logic [3:0] OPC_DIV   = 4'd6;
  localparam logic [3:0] OPC_MOD   = 4'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_DIVIDE,
    S_OUT,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [ADDR_W:0]   r_remaining;
  logic [ADDR_W-1:0] r_read_pointer;
  logic [ADDR_W-1:0] r_res_addr;
  logic [3:0]        r_opc;
  logic [OP_W-1:0]   r_a;
  logic [OP_W-1:0]   r_b;
  logic [RES_W-1:0]  r_res_data;
  logic              r_res_div0;

  logic [CNT_W-1:0]  r_div_cnt;
  logic [OP_W-1:0]   r_rem;
  logic [OP_W-1:0]   r_quo;
  logic [OP_W-1:0]   r_dvs;
  logic              r_neg_q;
  logic              r_neg_r;
  logic              r_is_mod;

  logic              w_is_div;
  logic              w_b_zero;
  logic [RES_W-1:0]  w_a_ext;
  logic [RES_W-1:0]  w_b_ext;
  logic [RES_W-1:0]  w_exec_res;
  logic [OP_W-1:0]   w_a_mag;
  logic [OP_W-1:0]   w_b_mag;
  logic [OP_W:0]     w_shift;
  logic [OP_W:0]     w_trial;
  logic [OP_W-1:0]   w_rem_next;
  logic [OP_W-1:0]   w_quo_next;
  logic [RES_W-1:0]  w_q_ext;
  logic [RES_W-1:0]  w_r_ext;
  logic [RES_W-1:0]  w_div_res;

  assign o_busy         = (r_state != S_IDLE);
  assign o_done         = (r_state == S_DONE);
  assign o_res_valid    = (r_state == S_OUT);
  assign o_read_pointer = r_read_pointer;
  assign o_res_addr     = r_res_addr;
  assign o_res_opc      = r_opc;
  assign o_res_data     = r_res_data;
  assign o_res_div0     = r_res_div0;

  assign w_is_div = (r_opc == OPC_DIV) || (r_opc == OPC_MOD);
  assign w_b_zero = (r_b == '0);

  // Operands widened before add/sub so the OP_W+1-bit true result survives sign extension.
  assign w_a_ext = {{(RES_W - OP_W){r_a[OP_W-1]}}, r_a};
  assign w_b_ext = {{(RES_W - OP_W){r_b[OP_W-1]}}, r_b};

  always_comb begin
    w_exec_res = '0;
    case (r_opc)
      OPC_ZERO:  w_exec_res = '0;
      OPC_PASSA: w_exec_res = w_a_ext;
      OPC_PASSB: w_exec_res = w_b_ext;
      OPC_ADD:   w_exec_res = w_a_ext + w_b_ext;
      OPC_SUB:   w_exec_res = w_a_ext - w_b_ext;
      OPC_MULT:  w_exec_res = w_a_ext * w_b_ext;
      default:   w_exec_res = '0;
    endcase
  end

  // Magnitude of the most negative value is still exact as an unsigned OP_W number.
  assign w_a_mag = r_a[OP_W-1] ? (~r_a + 1'b1) : r_a;
  assign w_b_mag = r_b[OP_W-1] ? (~r_b + 1'b1) : r_b;

  assign w_shift    = {r_rem, r_quo[OP_W-1]};
  assign w_trial    = w_shift - {1'b0, r_dvs};
  assign w_rem_next = w_trial[OP_W] ? w_shift[OP_W-1:0] : w_trial[OP_W-1:0];
  assign w_quo_next = {r_quo[OP_W-2:0], ~w_trial[OP_W]};
  assign w_q_ext    = {{(RES_W - OP_W){1'b0}}, w_quo_next};
  assign w_r_ext    = {{(RES_W - OP_W){1'b0}}, w_rem_next};
  assign w_div_res  = r_is_mod ? (r_neg_r ? (~w_r_ext + 1'b1) : w_r_ext)
                               : (r_neg_q ? (~w_q_ext + 1'b1) : w_q_ext);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_next_state = (i_count == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: w_next_state = S_EXEC;
      S_EXEC: begin
        w_next_state = (w_is_div && !w_b_zero) ? S_DIVIDE : S_OUT;
      end
      S_DIVIDE: begin
        if (r_div_cnt == DIV_LAST) begin
          w_next_state = S_OUT;
        end
      end
      S_OUT: begin
        if (i_res_ready) begin
          w_next_state = (r_remaining == LEFT_ONE) ? S_DONE : S_FETCH;
        end
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_remaining    <= '0;
      r_read_pointer <= '0;
      r_res_addr     <= '0;
      r_opc          <= '0;
      r_a            <= '0;
      r_b            <= '0;
      r_res_data     <= '0;
      r_res_div0     <= 1'b0;
      r_div_cnt      <= '0;
      r_rem          <= '0;
      r_quo          <= '0;
      r_dvs          <= '0;
      r_neg_q        <= 1'b0;
      r_neg_r        <= 1'b0;
      r_is_mod       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_read_pointer <= i_first_addr;
            r_remaining    <= i_count;
          end
        end
        S_FETCH: begin
          r_opc      <= i_instr_opc;
          r_a        <= i_instr_op_a;
          r_b        <= i_instr_op_b;
          r_res_addr <= r_read_pointer;
        end
        S_EXEC: begin
          r_res_data <= w_exec_res;
          r_res_div0 <= w_is_div && w_b_zero;
          r_rem      <= '0;
          r_quo      <= w_a_mag;
          r_dvs      <= w_b_mag;
          r_div_cnt  <= '0;
          r_neg_q    <= r_a[OP_W-1] ^ r_b[OP_W-1];
          r_neg_r    <= r_a[OP_W-1];
          r_is_mod   <= (r_opc == OPC_MOD);
        end
        S_DIVIDE: begin
          r_rem     <= w_rem_next;
          r_quo     <= w_quo_next;
          r_div_cnt <= r_div_cnt + CNT_ONE;
          if (r_div_cnt == DIV_LAST) begin
            r_res_data <= w_div_res;
          end
        end
        S_OUT: begin
          if (i_res_ready) begin
            r_remaining <= r_remaining - LEFT_ONE;
            if (r_remaining != LEFT_ONE) begin
              r_read_pointer <= r_read_pointer + PTR_ONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_exec_unit.sv
// tb/tb_instr_exec_unit.sv - directed self-checking bench for instr_exec_unit
module tb_instr_exec_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  first_addr;
  logic [5:0]  count;
  logic        busy;
  logic        done;
  logic [4:0]  read_pointer;
  logic [3:0]  instr_opc;
  logic [31:0] instr_op_a;
  logic [31:0] instr_op_b;
  logic        res_valid;
  logic        res_ready;
  logic [4:0]  res_addr;
  logic [3:0]  res_opc;
  logic [63:0] res_data;
  logic        res_div0;

  logic [3:0]  mem_opc [32];
  logic [31:0] mem_a   [32];
  logic [31:0] mem_b   [32];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    instr_opc  = mem_opc[read_pointer];
    instr_op_a = mem_a[read_pointer];
    instr_op_b = mem_b[read_pointer];
  end

  instr_exec_unit #(.OP_W(32), .RES_W(64), .ADDR_W(5)) dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_start        (start),
    .i_first_addr   (first_addr),
    .i_count        (count),
    .o_busy         (busy),
    .o_done         (done),
    .o_read_pointer (read_pointer),
    .i_instr_opc    (instr_opc),
    .i_instr_op_a   (instr_op_a),
    .i_instr_op_b   (instr_op_b),
    .o_res_valid    (res_valid),
    .i_res_ready    (res_ready),
    .o_res_addr     (res_addr),
    .o_res_opc      (res_opc),
    .o_res_data     (res_data),
    .o_res_div0     (res_div0)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_loc(input int idx, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    mem_opc[idx] = op;
    mem_a[idx]   = a;
    mem_b[idx]   = b;
  endtask

  task automatic start_seq(input logic [4:0] fa, input logic [5:0] cnt);
    first_addr = fa;
    count      = cnt;
    start      = 1'b1;
    step();
    start      = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_valid"}, res_valid, 0);
    chk({tag, "_rp"}, read_pointer, 0);
    chk({tag, "_addr"}, res_addr, 0);
    chk({tag, "_opc"}, res_opc, 0);
    chk({tag, "_data"}, res_data, 0);
    chk({tag, "_div0"}, res_div0, 0);
  endtask

  // Waits for a beat (res_ready held high by caller), checks it, then takes the handshake edge.
  // lat counts the cycle of start/previous handshake as cycle 0.
  task automatic expect_beat(input string tag, input logic [4:0] ea, input logic [3:0] eo,
                             input longint ed, input logic ez, input int el);
    int n = 0;
    while (!res_valid && n < 200) begin
      step();
      n++;
    end
    chk({tag, "_valid"}, res_valid, 1);
    chk({tag, "_addr"}, res_addr, ea);
    chk({tag, "_opc"}, res_opc, eo);
    chk({tag, "_data"}, res_data, ed);
    chk({tag, "_div0"}, res_div0, ez);
    chk({tag, "_lat"}, n + 1, el);
    step();
  endtask

  task automatic expect_done(input string tag);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_valid_in_done"}, res_valid, 0);
    step();
    chk({tag, "_done_clear"}, done, 0);
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) set_loc(i, 4'd0, 32'd0, 32'd0);
    set_loc(0, 4'd3, 32'd5, 32'd3);
    set_loc(1, 4'd4, 32'd2, 32'd9);
    set_loc(2, 4'd5, -32'sd4, 32'd6);
    set_loc(4, 4'd6, -32'sd15, 32'd4);
    set_loc(5, 4'd7, -32'sd15, 32'd4);
    set_loc(6, 4'd6, 32'd7, 32'd0);
    set_loc(7, 4'd6, 32'h8000_0000, 32'hFFFF_FFFF);
    set_loc(8, 4'd7, 32'd7, -32'sd2);
    set_loc(9, 4'd6, 32'd100, -32'sd7);
    set_loc(10, 4'd0, 32'hFFFF_FFFF, 32'd7);
    set_loc(11, 4'd1, 32'hFFFF_FFFF, 32'd7);
    set_loc(12, 4'd2, 32'hFFFF_FFFF, 32'd7);
    set_loc(13, 4'd8, 32'hFFFF_FFFF, 32'd7);
    set_loc(14, 4'd15, 32'hFFFF_FFFF, 32'd7);
    set_loc(15, 4'd3, 32'h7FFF_FFFF, 32'd1);
    set_loc(16, 4'd4, 32'h8000_0000, 32'd1);
    set_loc(17, 4'd5, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    set_loc(30, 4'd1, 32'd11, 32'd0);
    set_loc(31, 4'd2, 32'd0, 32'd22);

    reset = 1'b1;
    start = 1'b0;
    first_addr = '0;
    count = '0;
    res_ready = 1'b1;
    step();
    step();
    reset = 1'b0;
    check_idle_outputs("rst");

    // ADD / SUB / MULT stream
    start_seq(5'd0, 6'd3);
    expect_beat("t1_b0", 5'd0, 4'd3, 64'sd8, 1'b0, 3);
    expect_beat("t1_b1", 5'd1, 4'd4, -64'sd7, 1'b0, 3);
    expect_beat("t1_b2", 5'd2, 4'd5, -64'sd24, 1'b0, 3);
    expect_done("t1");

    // divider: signs, divide-by-zero, most-negative / -1
    start_seq(5'd4, 6'd6);
    expect_beat("t2_div", 5'd4, 4'd6, -64'sd3, 1'b0, 35);
    expect_beat("t2_mod", 5'd5, 4'd7, -64'sd3, 1'b0, 35);
    expect_beat("t2_div0", 5'd6, 4'd6, 64'sd0, 1'b1, 3);
    expect_beat("t2_minneg", 5'd7, 4'd6, 64'sd2147483648, 1'b0, 35);
    expect_beat("t2_modneg", 5'd8, 4'd7, 64'sd1, 1'b0, 35);
    expect_beat("t2_divneg", 5'd9, 4'd6, -64'sd14, 1'b0, 35);
    expect_done("t2");

    // address wrap and empty sequence
    start_seq(5'd30, 6'd4);
    expect_beat("t3_w30", 5'd30, 4'd1, 64'sd11, 1'b0, 3);
    expect_beat("t3_w31", 5'd31, 4'd2, 64'sd22, 1'b0, 3);
    expect_beat("t3_w0", 5'd0, 4'd3, 64'sd8, 1'b0, 3);
    expect_beat("t3_w1", 5'd1, 4'd4, -64'sd7, 1'b0, 3);
    expect_done("t3");
    start_seq(5'd3, 6'd0);
    expect_done("t3_cnt0");

    // back-pressure on beat 2 with an ignored start while busy
    start_seq(5'd0, 6'd3);
    expect_beat("t4_b0", 5'd0, 4'd3, 64'sd8, 1'b0, 3);
    res_ready = 1'b0;
    step();
    step();
    for (int k = 0; k < 5; k++) begin
      chk("t4_hold_valid", res_valid, 1);
      chk("t4_hold_data", res_data, -64'sd7);
      chk("t4_hold_addr", res_addr, 1);
      chk("t4_hold_rp", read_pointer, 1);
      if (k == 2) begin
        first_addr = 5'd20;
        count      = 6'd9;
        start      = 1'b1;
      end else begin
        start      = 1'b0;
      end
      step();
    end
    start = 1'b0;
    res_ready = 1'b1;
    expect_beat("t4_b1", 5'd1, 4'd4, -64'sd7, 1'b0, 1);
    expect_beat("t4_b2", 5'd2, 4'd5, -64'sd24, 1'b0, 3);
    expect_done("t4");
    chk("t4_rp_after", read_pointer, 2);

    // reset in the middle of a divide
    start_seq(5'd4, 6'd1);
    for (int k = 0; k < 10; k++) step();
    chk("t5_in_divide", busy, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_idle_outputs("t5_rst");
    for (int k = 0; k < 40; k++) begin
      chk("t5_no_done", done, 0);
      step();
    end
    start_seq(5'd4, 6'd1);
    expect_beat("t5_fresh", 5'd4, 4'd6, -64'sd3, 1'b0, 35);
    expect_done("t5");

    // misc opcodes and no-wrap arithmetic
    start_seq(5'd10, 6'd8);
    expect_beat("t6_zero", 5'd10, 4'd0, 64'sd0, 1'b0, 3);
    expect_beat("t6_passa", 5'd11, 4'd1, -64'sd1, 1'b0, 3);
    expect_beat("t6_passb", 5'd12, 4'd2, 64'sd7, 1'b0, 3);
    expect_beat("t6_op8", 5'd13, 4'd8, 64'sd0, 1'b0, 3);
    expect_beat("t6_op15", 5'd14, 4'd15, 64'sd0, 1'b0, 3);
    expect_beat("t6_addovf", 5'd15, 4'd3, 64'sd2147483648, 1'b0, 3);
    expect_beat("t6_subovf", 5'd16, 4'd4, -64'sd2147483649, 1'b0, 3);
    expect_beat("t6_multbig", 5'd17, 4'd5, 64'h3FFF_FFFF_0000_0001, 1'b0, 3);
    expect_done("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
